// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data read/write.
// Data has fixed priority; a burst counter forces a fetch grant after DATA_BURST_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_rreq,
  input  logic [31:0] d_raddr,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic [3:0]  d_wreq,
  input  logic [31:0] d_waddr,
  input  logic [31:0] d_wdata,
  output logic        d_wdone,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DREAD = 2'd2, DWRITE = 2'd3} state_t;

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= BURST_MAX) ? BURST_MAX : v + 4'd1;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic        mem_req_q, mem_req_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_wdone_q, d_wdone_d;

  // A requester whose completion pulse is high is releasing its request, so it is not re-served.
  logic f_elig, r_elig, w_elig, starve;
  assign f_elig = i_req && !i_rvalid_q;
  assign r_elig = d_rreq && !d_rvalid_q;
  assign w_elig = (d_wreq != 4'd0) && !d_wdone_q;
  assign starve = f_elig && (burst_q == BURST_MAX);

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_wdone_d   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (!i_req) burst_d = 4'd0;
        if (starve) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = i_addr;
          mem_we_d   = 4'd0;
          burst_d    = 4'd0;
        end else if (w_elig) begin
          state_d     = DWRITE;
          mem_req_d   = 1'b1;
          mem_addr_d  = d_waddr;
          mem_we_d    = d_wreq;
          mem_wdata_d = d_wdata;
          if (f_elig) burst_d = sat_inc(burst_q);
        end else if (r_elig) begin
          state_d    = DREAD;
          mem_req_d  = 1'b1;
          mem_addr_d = d_raddr;
          mem_we_d   = 4'd0;
          if (f_elig) burst_d = sat_inc(burst_q);
        end else if (f_elig) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = i_addr;
          mem_we_d   = 4'd0;
          burst_d    = 4'd0;
        end
      end
      FETCH: if (mem_ack) begin
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        i_rdata_d  = mem_rdata;
        i_rvalid_d = 1'b1;
      end
      DREAD: if (mem_ack) begin
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        d_rdata_d  = mem_rdata;
        d_rvalid_d = 1'b1;
      end
      DWRITE: if (mem_ack) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        d_wdone_d = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_q     <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_wdone_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rvalid_q  <= i_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_wdone_q   <= d_wdone_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_wdone   = d_wdone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory with configurable wait states,
// requesters that release on their completion pulse, and per-scenario checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_rreq;
  logic [31:0] i_addr, d_raddr, d_waddr, d_wdata;
  logic [3:0]  d_wreq;
  logic        i_rvalid, d_rvalid, d_wdone;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack, resp_ack, stray_ack;

  always #5 clk = ~clk;
  assign mem_ack = resp_ack | stray_ack;

  mem_port_arbiter #(.DATA_BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_rreq(d_rreq), .d_raddr(d_raddr), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wdone(d_wdone),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Requests may only be released together with their completion pulse.
  a_i_hold: assert property (@(posedge clk) disable iff (!reset) $fell(i_req) |-> i_rvalid)
    else $error("FAIL assert_i_req_dropped");
  a_r_hold: assert property (@(posedge clk) disable iff (!reset) $fell(d_rreq) |-> d_rvalid)
    else $error("FAIL assert_d_rreq_dropped");
  a_w_hold: assert property (@(posedge clk) disable iff (!reset)
                             ((|$past(d_wreq)) && !(|d_wreq)) |-> d_wdone)
    else $error("FAIL assert_d_wreq_dropped");

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural memory
  logic [31:0] mem [logic [31:0]];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic [31:0] wtmp;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hA5A5};
  endfunction

  initial begin
    resp_ack  = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end else if (resp_ack) begin
        resp_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= wait_cfg) begin
          resp_ack = 1'b1;
          wait_cnt = 0;
          if (mem_we == 4'd0) begin
            mem_rdata = mem_read(mem_addr);
          end else begin
            wtmp = mem_read(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_we[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = wtmp;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Scoreboard queues
  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } grant_t;

  grant_t      exp_g[$], obs_g[$];
  logic [31:0] exp_i_dat[$], exp_d_dat[$], obs_i_dat[$], obs_d_dat[$];
  int          obs_i_cyc[$], obs_d_cyc[$], obs_w_cyc[$];
  int          cyc, req_cycles, hold_bad;
  int          w_left, r_left;
  logic        prev_req;
  logic [3:0]  prev_we;
  logic [31:0] prev_addr, prev_wdata;

  function automatic grant_t mk(input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wdata);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata; g.cyc = 0;
    return g;
  endfunction

  task automatic clear_obs();
    exp_g.delete(); obs_g.delete();
    exp_i_dat.delete(); exp_d_dat.delete(); obs_i_dat.delete(); obs_d_dat.delete();
    obs_i_cyc.delete(); obs_d_cyc.delete(); obs_w_cyc.delete();
    cyc = 0; req_cycles = 0; hold_bad = 0;
    prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
  endtask

  // Advance n cycles, sampling on the falling edge; requesters release on their pulse.
  task automatic run_cycles(input int n);
    grant_t g;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        req_cycles++;
        if (!prev_req) begin
          g.we = mem_we; g.addr = mem_addr; g.wdata = mem_wdata; g.cyc = cyc;
          obs_g.push_back(g);
        end else if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) begin
          hold_bad++;
        end
      end
      if (i_rvalid) begin
        obs_i_cyc.push_back(cyc); obs_i_dat.push_back(i_rdata);
        i_req = 1'b0;
      end
      if (d_rvalid) begin
        obs_d_cyc.push_back(cyc); obs_d_dat.push_back(d_rdata);
        if (r_left > 1) r_left--; else begin r_left = 0; d_rreq = 1'b0; end
      end
      if (d_wdone) begin
        obs_w_cyc.push_back(cyc);
        if (w_left > 1) w_left--; else begin w_left = 0; d_wreq = 4'd0; end
      end
      prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    tests_run++;
    if (mem_we !== 4'd0) begin tests_failed++; $display("FAIL rst_mem_we got %h want 0", mem_we); end
    tests_run++;
    if (mem_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    tests_run++;
    if (mem_wdata !== 32'd0) begin tests_failed++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    tests_run++;
    if ({i_rvalid, d_rvalid, d_wdone} !== 3'b000) begin
      tests_failed++; $display("FAIL rst_pulses got %b want 000", {i_rvalid, d_rvalid, d_wdone});
    end
    tests_run++;
    if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      tests_failed++; $display("FAIL rst_rdata got i=%h d=%h want 0", i_rdata, d_rdata);
    end
  endtask

  task automatic test_fetch_after_reset();
    grant_t e, o;
    mem[32'h100] = 32'h0050_0093;
    i_req = 1'b1; i_addr = 32'h100;
    clear_obs();
    exp_g.push_back(mk(4'd0, 32'h100, 32'd0));
    exp_i_dat.push_back(32'h0050_0093);
    reset = 1'b1;
    run_cycles(4);
    tests_run++;
    if (obs_g.size() != 1 || obs_g[0].cyc != 1) begin
      tests_failed++; $display("FAIL fa_grant_cycle got n=%0d cyc=%0d want n=1 cyc=1", obs_g.size(), obs_g[0].cyc);
    end
    tests_run++;
    if (obs_i_cyc.size() != 1 || obs_i_cyc[0] != 2) begin
      tests_failed++; $display("FAIL fa_rvalid_cycle got n=%0d cyc=%0d want n=1 cyc=2", obs_i_cyc.size(), obs_i_cyc[0]);
    end
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      e = exp_g.pop_front(); o = obs_g.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.we !== e.we) begin
        tests_failed++; $display("FAIL fa_grant got we=%h addr=%h want we=%h addr=%h", o.we, o.addr, e.we, e.addr);
      end
    end
    while (exp_i_dat.size() > 0 && obs_i_dat.size() > 0) begin
      tests_run++;
      if (obs_i_dat[0] !== exp_i_dat[0]) begin
        tests_failed++; $display("FAIL fa_i_rdata got %h want %h", obs_i_dat[0], exp_i_dat[0]);
      end
      void'(obs_i_dat.pop_front()); void'(exp_i_dat.pop_front());
    end
  endtask

  task automatic test_simultaneous();
    grant_t e, o;
    mem[32'h1000] = 32'h1111_2222;
    mem[32'h200]  = 32'h3333_4444;
    clear_obs();
    exp_g.push_back(mk(4'hF, 32'h1004, 32'hDEAD_BEEF));
    exp_g.push_back(mk(4'h0, 32'h1000, 32'd0));
    exp_g.push_back(mk(4'h0, 32'h200, 32'd0));
    exp_d_dat.push_back(32'h1111_2222);
    exp_i_dat.push_back(32'h3333_4444);
    i_req = 1'b1; i_addr = 32'h200;
    d_rreq = 1'b1; d_raddr = 32'h1000;
    d_wreq = 4'hF; d_waddr = 32'h1004; d_wdata = 32'hDEAD_BEEF;
    run_cycles(10);
    tests_run++;
    if (obs_g.size() != exp_g.size()) begin
      tests_failed++; $display("FAIL sim_grant_count got %0d want %0d", obs_g.size(), exp_g.size());
    end
    tests_run++;
    if (obs_w_cyc.size() != 1 || obs_d_cyc.size() != 1 || obs_i_cyc.size() != 1) begin
      tests_failed++; $display("FAIL sim_pulse_counts got w=%0d d=%0d i=%0d want 1 1 1",
                               obs_w_cyc.size(), obs_d_cyc.size(), obs_i_cyc.size());
    end
    tests_run++;
    if (obs_w_cyc.size() < 1 || obs_g.size() < 2 || !(obs_w_cyc[0] < obs_g[1].cyc)) begin
      tests_failed++; $display("FAIL sim_raw_order got wdone_cyc=%0d read_grant_cyc=%0d want wdone first",
                               obs_w_cyc[0], obs_g[1].cyc);
    end
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      e = exp_g.pop_front(); o = obs_g.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.we !== e.we || (e.we != 4'd0 && o.wdata !== e.wdata)) begin
        tests_failed++; $display("FAIL sim_grant got we=%h addr=%h wdata=%h want we=%h addr=%h wdata=%h",
                                 o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
      end
    end
    tests_run++;
    if (obs_d_dat.size() < 1 || obs_d_dat[0] !== exp_d_dat[0]) begin
      tests_failed++; $display("FAIL sim_d_rdata got %h want %h", obs_d_dat[0], exp_d_dat[0]);
    end
    tests_run++;
    if (obs_i_dat.size() < 1 || obs_i_dat[0] !== exp_i_dat[0]) begin
      tests_failed++; $display("FAIL sim_i_rdata got %h want %h", obs_i_dat[0], exp_i_dat[0]);
    end
  endtask

  task automatic test_starvation();
    grant_t e, o;
    int gi;
    clear_obs();
    for (int k = 0; k < 2; k++) begin
      exp_g.push_back(mk(4'hF, 32'h3000, 32'h1234_5678));
      exp_g.push_back(mk(4'h0, 32'h3000, 32'd0));
    end
    exp_g.push_back(mk(4'h0, 32'h300, 32'd0));
    exp_g.push_back(mk(4'hF, 32'h3000, 32'h1234_5678));
    exp_g.push_back(mk(4'h0, 32'h3000, 32'd0));
    for (int k = 0; k < 3; k++) exp_d_dat.push_back(32'h1234_5678);
    exp_i_dat.push_back(32'h0300_A5A5);
    w_left = 3; r_left = 3;
    i_req = 1'b1; i_addr = 32'h300;
    d_wreq = 4'hF; d_waddr = 32'h3000; d_wdata = 32'h1234_5678;
    d_rreq = 1'b1; d_raddr = 32'h3000;
    run_cycles(20);
    tests_run++;
    if (obs_g.size() != exp_g.size()) begin
      tests_failed++; $display("FAIL starve_grant_count got %0d want %0d", obs_g.size(), exp_g.size());
    end
    tests_run++;
    if (obs_w_cyc.size() != 3 || obs_d_cyc.size() != 3 || obs_i_cyc.size() != 1) begin
      tests_failed++; $display("FAIL starve_pulse_counts got w=%0d d=%0d i=%0d want 3 3 1",
                               obs_w_cyc.size(), obs_d_cyc.size(), obs_i_cyc.size());
    end
    gi = 0;
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      e = exp_g.pop_front(); o = obs_g.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.we !== e.we || (e.we != 4'd0 && o.wdata !== e.wdata)) begin
        tests_failed++; $display("FAIL starve_grant%0d got we=%h addr=%h want we=%h addr=%h",
                                 gi, o.we, o.addr, e.we, e.addr);
      end
      gi++;
    end
    while (exp_d_dat.size() > 0 && obs_d_dat.size() > 0) begin
      tests_run++;
      if (obs_d_dat[0] !== exp_d_dat[0]) begin
        tests_failed++; $display("FAIL starve_d_rdata got %h want %h", obs_d_dat[0], exp_d_dat[0]);
      end
      void'(obs_d_dat.pop_front()); void'(exp_d_dat.pop_front());
    end
    tests_run++;
    if (obs_i_dat.size() < 1 || obs_i_dat[0] !== exp_i_dat[0]) begin
      tests_failed++; $display("FAIL starve_i_rdata got %h want %h", obs_i_dat[0], exp_i_dat[0]);
    end
  endtask

  task automatic test_wait_states();
    clear_obs();
    wait_cfg = 3;
    exp_g.push_back(mk(4'b0011, 32'h2002, 32'hCAFE_F00D));
    d_wreq = 4'b0011; d_waddr = 32'h2002; d_wdata = 32'hCAFE_F00D;
    run_cycles(2);
    d_waddr = 32'hFFFF_0000; d_wdata = 32'h0;
    run_cycles(6);
    wait_cfg = 0;
    tests_run++;
    if (obs_g.size() != 1 || obs_g[0].addr !== exp_g[0].addr || obs_g[0].we !== exp_g[0].we
        || obs_g[0].wdata !== exp_g[0].wdata) begin
      tests_failed++; $display("FAIL ws_grant got n=%0d we=%h addr=%h wdata=%h want we=%h addr=%h wdata=%h",
                               obs_g.size(), obs_g[0].we, obs_g[0].addr, obs_g[0].wdata,
                               exp_g[0].we, exp_g[0].addr, exp_g[0].wdata);
    end
    tests_run++;
    if (hold_bad != 0) begin tests_failed++; $display("FAIL ws_hold got %0d changes want 0", hold_bad); end
    tests_run++;
    if (req_cycles != 4) begin tests_failed++; $display("FAIL ws_req_cycles got %0d want 4", req_cycles); end
    tests_run++;
    if (obs_w_cyc.size() != 1 || obs_w_cyc[0] != obs_g[0].cyc + 4) begin
      tests_failed++; $display("FAIL ws_wdone got n=%0d cyc=%0d want n=1 cyc=%0d",
                               obs_w_cyc.size(), obs_w_cyc[0], obs_g[0].cyc + 4);
    end
  endtask

  task automatic test_reset_mid_access();
    clear_obs();
    mem[32'h4000] = 32'h0BAD_CAFE;
    wait_cfg = 5;
    d_rreq = 1'b1; d_raddr = 32'h4000;
    run_cycles(2);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rma_async_req got %b want 0", mem_req); end
    run_cycles(2);
    tests_run++;
    if (obs_d_cyc.size() != 0) begin tests_failed++; $display("FAIL rma_no_rvalid got %0d pulses want 0", obs_d_cyc.size()); end
    wait_cfg = 0;
    clear_obs();
    exp_g.push_back(mk(4'd0, 32'h4000, 32'd0));
    exp_d_dat.push_back(32'h0BAD_CAFE);
    reset = 1'b1;
    run_cycles(5);
    tests_run++;
    if (obs_g.size() != 1 || obs_g[0].addr !== exp_g[0].addr || obs_g[0].cyc != 1) begin
      tests_failed++; $display("FAIL rma_regrant got n=%0d addr=%h cyc=%0d want n=1 addr=%h cyc=1",
                               obs_g.size(), obs_g[0].addr, obs_g[0].cyc, exp_g[0].addr);
    end
    tests_run++;
    if (obs_d_dat.size() != 1 || obs_d_dat[0] !== exp_d_dat[0]) begin
      tests_failed++; $display("FAIL rma_d_rdata got n=%0d data=%h want n=1 data=%h",
                               obs_d_dat.size(), obs_d_dat[0], exp_d_dat[0]);
    end
  endtask

  task automatic test_stray_ack();
    clear_obs();
    stray_ack = 1'b1;
    run_cycles(1);
    stray_ack = 1'b0;
    run_cycles(3);
    tests_run++;
    if (req_cycles != 0 || obs_g.size() != 0) begin
      tests_failed++; $display("FAIL stray_req got %0d req cycles want 0", req_cycles);
    end
    tests_run++;
    if (obs_i_cyc.size() + obs_d_cyc.size() + obs_w_cyc.size() != 0) begin
      tests_failed++; $display("FAIL stray_pulses got %0d want 0",
                               obs_i_cyc.size() + obs_d_cyc.size() + obs_w_cyc.size());
    end
    tests_run++;
    if (d_rdata !== 32'h0BAD_CAFE) begin
      tests_failed++; $display("FAIL stray_d_rdata_hold got %h want %h", d_rdata, 32'h0BAD_CAFE);
    end
    mem[32'h500] = 32'h00A0_0113;
    clear_obs();
    exp_i_dat.push_back(32'h00A0_0113);
    i_req = 1'b1; i_addr = 32'h500;
    run_cycles(4);
    tests_run++;
    if (obs_g.size() != 1 || obs_g[0].cyc != 1 || obs_i_cyc.size() != 1 || obs_i_cyc[0] != 2) begin
      tests_failed++; $display("FAIL stray_idle_fetch got grant_cyc=%0d rvalid_cyc=%0d want 1 2",
                               obs_g[0].cyc, obs_i_cyc[0]);
    end
    tests_run++;
    if (obs_i_dat.size() != 1 || obs_i_dat[0] !== exp_i_dat[0]) begin
      tests_failed++; $display("FAIL stray_i_rdata got %h want %h", obs_i_dat[0], exp_i_dat[0]);
    end
  endtask

  initial begin
    reset = 1'b0; stray_ack = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_rreq = 1'b0; d_raddr = 32'd0;
    d_wreq = 4'd0; d_waddr = 32'd0; d_wdata = 32'd0;
    w_left = 0; r_left = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch_after_reset();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_reset_mid_access();
    test_stray_ack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
